// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Holds the scan FSM state type, the reset column drive and the key map lookup.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    localparam logic [3:0] ColReset = 4'b1110;

    // Nibble at index {row, col} holds the hex code printed on that key.
    localparam logic [63:0] KeyMap = 64'hDEF0_C987_B654_A321;

    // Lowest low row wins when several rows read low in the driven column.
    function automatic logic [3:0] key_lookup(input logic [3:0] row_pat,
                                              input logic [3:0] col_drv);
        logic [1:0] r_idx;
        logic [1:0] c_idx;
        r_idx = 2'd0;
        c_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_pat[i]) r_idx = 2'(i);
            if (!col_drv[i]) c_idx = 2'(i);
        end
        return KeyMap[{r_idx, c_idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan tick generator: one-cycle tick every SCAN_DIV clocks.
module keypad_tick_gen #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntLast);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounced press/release and a one-cycle key_valid per press.
// Define KEYPAD_ACCUM_EN to shift each accepted digit into value (clr clears it).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clr,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] value
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT);

    logic            tick;
    logic [3:0]      row_meta_q, row_sync_q;
    state_e          state_q, state_d;
    logic [3:0]      col_q, col_d;
    logic [3:0]      pat_q, pat_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            all_high;
    logic [3:0]      col_rot;
    logic [CntW-1:0] cnt_inc;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // Rows are asynchronous to clk; reset to the idle (all released) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    assign all_high = (row_sync_q == 4'hF);
    assign col_rot  = {col_q[2:0], col_q[3]};
    assign cnt_inc  = cnt_q + CntOne;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (all_high) begin
                        col_d = col_rot;
                    end else begin
                        pat_d = row_sync_q;
                        cnt_d = CntOne;
                        if (CntOne == CntMax) begin
                            state_d     = StPressed;
                            key_code_d  = key_lookup(row_sync_q, col_q);
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = StDebounce;
                        end
                    end
                end
                StDebounce: begin
                    if (all_high) begin
                        state_d = StScan;
                        col_d   = col_rot;
                    end else if (row_sync_q == pat_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntMax) begin
                            state_d     = StPressed;
                            key_code_d  = key_lookup(row_sync_q, col_q);
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        pat_d = row_sync_q;
                        cnt_d = CntOne;
                    end
                end
                StPressed: begin
                    if (all_high) begin
                        cnt_d = CntOne;
                        if (CntOne == CntMax) begin
                            state_d = StScan;
                            col_d   = col_rot;
                        end else begin
                            state_d = StRelease;
                        end
                    end
                end
                StRelease: begin
                    if (all_high) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntMax) begin
                            state_d = StScan;
                            col_d   = col_rot;
                        end
                    end else begin
                        state_d = StPressed;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StScan;
            col_q       <= ColReset;
            pat_q       <= 4'hF;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == StPressed) || (state_q == StRelease);

`ifdef KEYPAD_ACCUM_EN
    logic [15:0] value_q, value_d;

    // clr beats a simultaneous accept.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 16'h0000;
        end else if (key_valid_d) begin
            value_d = {value_q[11:0], key_code_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 16'h0000;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign value      = {12'h000, key_code_q};
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: simulated key matrix, tick-level reference
// model of the scan/debounce rules, directed scenarios and randomized key activity.
module tb_keypad_scanner;

    localparam int unsigned ScanDiv = 4;
    localparam int unsigned DebCnt  = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr   = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] value;

    logic [15:0] keys_down = 16'h0000;  // bit r*4+c set: key at row r, column c pressed

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int valid_seen = 0;

    // Reference model: scan column index, held flag and a single debounce count.
    int          m_colidx;
    int          m_cnt;
    bit          m_held;
    bit          m_valid;
    logic [3:0]  m_pat;
    logic [3:0]  m_code;
    logic [15:0] m_value;

    int key_map[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_down[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .SCAN_DIV     (ScanDiv),
        .DEBOUNCE_CNT (DebCnt)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .clr       (clr),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .value     (value)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] col_of(input int ci);
        return ~(4'b0001 << ci);
    endfunction

    function automatic logic [3:0] sample(input logic [15:0] keys, input int ci);
        logic [3:0] s;
        s = 4'hF;
        for (int r = 0; r < 4; r++) if (keys[r*4+ci]) s[r] = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] decode(input logic [3:0] pat, input int ci);
        int rr;
        rr = 0;
        for (int r = 3; r >= 0; r--) if (!pat[r]) rr = r;
        return 4'(key_map[rr*4+ci]);
    endfunction

    task automatic model_reset();
        m_colidx = 0;
        m_cnt    = 0;
        m_held   = 0;
        m_valid  = 0;
        m_pat    = 4'hF;
        m_code   = 4'h0;
        m_value  = 16'h0000;
    endtask

    task automatic model_tick();
        logic [3:0] s;
        s = sample(keys_down, m_colidx);
        if (!m_held) begin
            if (s == 4'hF) begin
                m_cnt    = 0;
                m_colidx = (m_colidx + 1) % 4;
            end else begin
                if (m_cnt > 0 && s == m_pat) begin
                    m_cnt++;
                end else begin
                    m_pat = s;
                    m_cnt = 1;
                end
                if (m_cnt >= DebCnt) begin
                    m_held  = 1;
                    m_cnt   = 0;
                    m_code  = decode(s, m_colidx);
                    m_valid = 1;
                end
            end
        end else if (s != 4'hF) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt >= DebCnt) begin
                m_held   = 0;
                m_cnt    = 0;
                m_colidx = (m_colidx + 1) % 4;
            end
        end
    endtask

    // Advances the model across the coming clock edge.
    task automatic model_step();
        m_valid = 0;
        if (cyc % ScanDiv == ScanDiv - 1) model_tick();
`ifdef KEYPAD_ACCUM_EN
        if (clr) m_value = 16'h0000;
        else if (m_valid) m_value = {m_value[11:0], m_code};
`else
        m_value = {12'h000, m_code};
`endif
    endtask

    task automatic one_cycle(input bit rand_clr);
        check("col", 16'(col), 16'(col_of(m_colidx)));
        check("key_held", 16'(key_held), 16'(m_held));
        check("key_valid", 16'(key_valid), 16'(m_valid));
        check("key_code", 16'(key_code), 16'(m_code));
        check("value", value, m_value);
        if (key_valid) valid_seen++;
        clr = rand_clr && ($urandom_range(0, 9) == 0);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_ticks(input int n, input bit rand_clr);
        repeat (n * ScanDiv) one_cycle(rand_clr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        #2;
        check("rst_col", 16'(col), 16'h000E);
        check("rst_held", 16'(key_held), 16'h0000);
        check("rst_valid", 16'(key_valid), 16'h0000);
        check("rst_code", 16'(key_code), 16'h0000);
        check("rst_value", value, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic press_release(input int bit_idx, input int hold, input int rel);
        keys_down = 16'h0000;
        keys_down[bit_idx] = 1'b1;
        run_ticks(hold, 0);
        keys_down = 16'h0000;
        run_ticks(rel, 0);
    endtask

    initial begin
        logic [15:0] accum_exp[5];
        int          accum_bit[5];
        logic [3:0]  accum_dig[5];
        int          k;
        accum_exp = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23AB};
        accum_bit = '{0, 1, 2, 3, 7};
        accum_dig = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB};

        #1;
        do_reset();

        // Idle scan
        valid_seen = 0;
        run_ticks(6, 0);
        check("idle_valid_count", 16'(valid_seen), 16'd0);

        // Single press of '6' (row1/col2) held for 40 cycles
        valid_seen = 0;
        press_release(6, 10, 6);
        check("single_valid_count", 16'(valid_seen), 16'd1);
        check("single_code", 16'(key_code), 16'h0006);

        // Bounce on '5' then a steady press
        valid_seen = 0;
        for (int i = 0; i < 5; i++) begin
            keys_down = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            run_ticks(1, 0);
        end
        keys_down = 16'h0020;
        run_ticks(8, 0);
        keys_down = 16'h0000;
        run_ticks(5, 0);
        check("bounce_valid_count", 16'(valid_seen), 16'd1);

        // Accumulate 1, 2, 3, A, B
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press_release(accum_bit[i], 10, 5);
`ifdef KEYPAD_ACCUM_EN
            check("accum_value", value, accum_exp[i]);
`else
            check("accum_value", value, {12'h000, accum_dig[i]});
`endif
        end

        // Release glitch on '9'
        valid_seen = 0;
        keys_down = 16'h0400;
        run_ticks(10, 0);
        keys_down = 16'h0000;
        run_ticks(1, 0);
        keys_down = 16'h0400;
        run_ticks(1, 0);
        check("glitch_held", 16'(key_held), 16'h0001);
        run_ticks(2, 0);
        keys_down = 16'h0000;
        run_ticks(5, 0);
        check("glitch_valid_count", 16'(valid_seen), 16'd1);

        // Rows 0 and 3 low on col0: lowest row wins
        keys_down = 16'h1001;
        run_ticks(10, 0);
        check("multirow_code", 16'(key_code), 16'h0001);
        keys_down = 16'h0000;
        run_ticks(5, 0);

        // Reset in the middle of debouncing, then re-detect the still-held key
        keys_down = 16'h0001;
        k = 0;
        while (!(!m_held && m_cnt > 0) && k < 40) begin
            one_cycle(0);
            k++;
        end
        if (k >= 40) check("debounce_timeout", 16'd0, 16'd1);
        do_reset();
        valid_seen = 0;
        run_ticks(8, 0);
        check("redetect_valid_count", 16'(valid_seen), 16'd1);
        keys_down = 16'h0000;
        run_ticks(5, 0);

        // Randomized key activity with occasional clr
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: keys_down = 16'h0000;
                1, 2: begin
                    keys_down = 16'h0000;
                    keys_down[$urandom_range(0, 15)] = 1'b1;
                end
                default: begin
                    keys_down = 16'h0000;
                    keys_down[$urandom_range(0, 15)] = 1'b1;
                    keys_down[$urandom_range(0, 15)] = 1'b1;
                end
            endcase
            run_ticks($urandom_range(1, 8), 1);
        end
        keys_down = 16'h0000;
        run_ticks(6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
